mnist_window_gen: RTL
=====================

Name: mnist_window_gen

Overview:
Upstream feeder for simpleCNN. It accepts one 28x28 8-bit image as a raster pixel stream, one pixel per accepted cycle. It produces every 5x5 window, 576 per image, with the window's top-left coordinates, in the exact IMGIN/X/Y packing that simpleCNN consumes. It also generates the per-image START pulse. It replaces bench-side window extraction, so the classifier can be fed directly from memory or a camera stream.

Parameters:
IMG_W, 28, image width in pixels (columns)
IMG_H, 28, image height in pixels (rows)
K, 5, window edge length
PIX_W, 8, bits per pixel

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
SOF  in  1  start of frame; qualifies the pixel with PIX_VALID as pixel (0,0)
PIX_VALID  in  1  pixel present on PIX_IN this cycle
PIX_IN  in  PIX_W  pixel value, raster order (row-major, column fastest)
START  out  1  one-cycle pulse to simpleCNN at frame start
WIN_VALID  out  1  window on IMGIN/X/Y valid this cycle
X  out  5  window top-left row, 0..IMG_H-K
Y  out  5  window top-left column, 0..IMG_W-K
IMGIN  out  K*K*PIX_W (200)  window; byte (k*K+l) at bits [(k*K+l)*8 +: 8] = pixel(row X+k, col Y+l)
WIN_LAST  out  1  qualifies final window of frame (X=IMG_H-K, Y=IMG_W-K)
BUSY  out  1  frame in progress

Behaviour:
- Reset (nRST=0 at a CLK edge): all outputs 0, state IDLE, counters r=c=0.
  - Line-buffer and window-register contents need no reset; they are never emitted before being rewritten.
- States: IDLE, RUN.
  - IDLE: PIX_VALID without SOF is ignored.
  - IDLE: SOF&PIX_VALID accepts the pixel as (0,0), sets c=1, enters RUN and asserts BUSY.
  - RUN: each PIX_VALID accepts a pixel at the current (r,c), then c increments; at c=IMG_W-1, c wraps to 0 and r increments.
  - RUN: accepting pixel (IMG_H-1, IMG_W-1) returns to IDLE and clears BUSY the next cycle.
- START: asserted the cycle after the SOF pixel is accepted, for exactly one cycle. It always precedes the first WIN_VALID.
- SOF&PIX_VALID while in RUN: the frame is abandoned, no WIN_LAST is issued, and the pixel becomes (0,0) of a new frame. START pulses again.
- PIX_VALID gaps are allowed anywhere. The outputs simply do not advance during a gap; no window is emitted or repeated.
- Storage:
  - K-1 line buffers, each IMG_W x PIX_W, holding rows r-4..r-1 indexed by c.
  - K x K window register.
  - On accept, the column vector {lb[r-4][c]..lb[r-1][c], PIX_IN} shifts into the window's rightmost column, and the line buffers rotate at column c.
- Emission: when the accepted pixel has r>=K-1 and c>=K-1, the next cycle drives WIN_VALID=1, X=r-(K-1), Y=c-(K-1) and the packed IMGIN.
  - Latency: exactly 1 cycle from accept to WIN_VALID.
  - WIN_VALID is high for one cycle per window, with no backpressure; downstream consumes every valid cycle.
  - X, Y and IMGIN hold their last values when WIN_VALID=0.
- Window order: Y fastest, then X, i.e. (0,0),(0,1)..(0,23),(1,0)..(23,23). The order is identical to simpleCNN's expected order.
- WIN_LAST=1 only together with the WIN_VALID of window (23,23).
- Counts per frame: 784 pixels accepted, 576 windows, the first after pixel index 116 (row 4, col 4).
- Mid-operation reset: outputs are 0 the next cycle and the frame is discarded. A new SOF is required.
- Widths: X/Y are sized for defaults (max 23 < 32). r/c counters are 5 bits. No arithmetic on pixel data.

Test Plan:
- Ramp frame, PIX_VALID continuous, pixel(r,c)=(r*28+c) mod 256 -> START 1 cycle after SOF pixel. First WIN_VALID the cycle after pixel 116, with X=0, Y=0, IMGIN bytes 0=0x00, 4=0x04, 5=0x1C, 24=0x74.
- Same frame -> exactly 576 WIN_VALID pulses in order (0,0)..(23,23). Window (23,23) has WIN_LAST=1 and byte 24=0x0F (783 mod 256). Spot-check window (10,7) byte 12 = ((12*28+9) mod 256)=0x59. BUSY drops after the last pixel.
- Ramp frame with PIX_VALID toggling randomly at ~50% duty -> identical window sequence and contents to the continuous case; no duplicated or dropped windows; WIN_VALID never high on a cycle not following an accept.
- SOF reasserted at pixel 300 of frame 1, followed by a full frame 2 -> no WIN_LAST for frame 1, a second START pulse, then 576 correct frame-2 windows.
- nRST=0 for 1 cycle at pixel 500 -> all outputs 0 the next cycle. Pixels without SOF are ignored (no WIN_VALID). A subsequent SOF frame yields 576 correct windows.
- 100 back-to-back frames from the existing image file, with simpleCNN connected downstream -> each frame produces one DONE. Classification results match the bench-fed flow for all 100 labels.

Source files
------------

// File: rtl/mnist_window_gen_if.sv
// mnist_window_gen_if: raster pixel stream in, 5x5 window stream out
interface mnist_window_gen_if #(
  parameter int PIX_W = 8,
  parameter int K = 5
);
  logic SOF;
  logic PIX_VALID;
  logic [PIX_W-1:0] PIX_IN;
  logic START;
  logic WIN_VALID;
  logic [4:0] X;
  logic [4:0] Y;
  logic [K*K*PIX_W-1:0] IMGIN;
  logic WIN_LAST;
  logic BUSY;
  modport master (
    output SOF, PIX_VALID, PIX_IN,
    input START, WIN_VALID, X, Y, IMGIN, WIN_LAST, BUSY
  );
  modport slave (
    input SOF, PIX_VALID, PIX_IN,
    output START, WIN_VALID, X, Y, IMGIN, WIN_LAST, BUSY
  );
endinterface

// File: rtl/mnist_window_gen.sv
// mnist_window_gen: turns a raster image stream into every KxK window for simpleCNN
module mnist_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K = 5,
  parameter int PIX_W = 8
) (
  input logic CLK,
  input logic nRST,
  mnist_window_gen_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [4:0] C_MAX = 5'(IMG_W - 1);
  localparam logic [4:0] R_MAX = 5'(IMG_H - 1);
  localparam logic [4:0] K_M1 = 5'(K - 1);
  state_t state, state_nx;
  logic [4:0] r, c, r_nx, c_nx, cur_r, cur_c;
  logic sof_acc, acc, last, emit;
  logic [PIX_W-1:0] lb [K-1][IMG_W];
  logic [PIX_W-1:0] win [K][K];
  logic [PIX_W-1:0] win_nx [K][K];
  logic [PIX_W-1:0] col [K];
  logic [K*K*PIX_W-1:0] img_nx;
  // SOF restarts the frame at (0,0) from any state; otherwise only RUN accepts
  always_comb begin
    sof_acc = bus.PIX_VALID && bus.SOF;
    acc = sof_acc || (bus.PIX_VALID && state == RUN);
    cur_r = sof_acc ? '0 : r;
    cur_c = sof_acc ? '0 : c;
    last = cur_r == R_MAX && cur_c == C_MAX;
    emit = acc && cur_r >= K_M1 && cur_c >= K_M1;
    state_nx = acc ? (last ? IDLE : RUN) : state;
    c_nx = !acc ? c : (cur_c == C_MAX ? '0 : cur_c + 5'd1);
    r_nx = !acc ? r : (last ? '0 : cur_r + 5'(cur_c == C_MAX));
  end
  // frame position and state registers
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      r <= '0;
      c <= '0;
    end else begin
      state <= state_nx;
      r <= r_nx;
      c <= c_nx;
    end
  end
  // column from the line buffers plus the new pixel shifts into the window's right edge
  always_comb begin
    col[K-1] = bus.PIX_IN;
    for (int k = 0; k < K-1; k++) col[k] = lb[k][cur_c];
    img_nx = '0;
    for (int k = 0; k < K; k++) begin
      for (int l = 0; l < K-1; l++) win_nx[k][l] = win[k][l+1];
      win_nx[k][K-1] = col[k];
      for (int l = 0; l < K; l++) img_nx[(k*K+l)*PIX_W +: PIX_W] = win_nx[k][l];
    end
  end
  // line buffers rotate up one row at the current column; contents need no reset
  always_ff @(posedge CLK) begin
    if (acc) begin
      for (int k = 0; k < K-1; k++) lb[k][cur_c] <= col[k+1];
      win <= win_nx;
    end
  end
  // registered outputs; window fields hold between emissions
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      bus.START <= 1'b0;
      bus.WIN_VALID <= 1'b0;
      bus.WIN_LAST <= 1'b0;
      bus.X <= '0;
      bus.Y <= '0;
      bus.IMGIN <= '0;
    end else begin
      bus.START <= sof_acc;
      bus.WIN_VALID <= emit;
      bus.WIN_LAST <= emit && last;
      if (emit) begin
        bus.X <= cur_r - K_M1;
        bus.Y <= cur_c - K_M1;
        bus.IMGIN <= img_nx;
      end
    end
  end
  assign bus.BUSY = state == RUN;
endmodule
